// File: rtl/reorder_buffer_pkg.sv
// Shared constants, entry kinds and redirect helpers for the reorder buffer.
// Imported by the top and by the operand bypass lookup.
package reorder_buffer_pkg;

  localparam int DEF_ROB_WIDTH_BIT = 3;
  localparam int DEF_NUM_WB        = 2;
  localparam int DEF_REG_ID_BIT    = 5;

  typedef enum logic [1:0] {
    ROB_KIND_NORMAL = 2'd0,
    ROB_KIND_BRANCH = 2'd1,
    ROB_KIND_JALR   = 2'd2,
    ROB_KIND_EXIT   = 2'd3
  } rob_kind_e;

  // A retiring jalr always refetches; a branch refetches only when the predictor was wrong.
  function automatic logic rob_mispredict(input logic [1:0] kind, input logic pred, input logic taken);
    logic r;
    r = 1'b0;
    case (kind)
      ROB_KIND_BRANCH: r = (taken != pred);
      ROB_KIND_JALR:   r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rob_redirect_pc(input logic [1:0] kind, input logic [31:0] pc,
                                                  input logic taken, input logic [31:0] target);
    logic [31:0] r;
    if ((kind == ROB_KIND_JALR) || taken) begin
      r = target;
    end else begin
      r = pc + 32'd4;
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_buffer_bypass.sv
// Operand lookup: returns a result either from the buffer or from a writeback
// arriving this cycle (lowest-numbered channel wins).
module rob_bypass
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT,
  parameter int NUM_WB        = DEF_NUM_WB
) (
  input  logic [ROB_WIDTH_BIT-1:0]                   q_id,
  input  logic [(2**ROB_WIDTH_BIT)-1:0]              busy,
  input  logic [(2**ROB_WIDTH_BIT)-1:0]              ready,
  input  logic [(2**ROB_WIDTH_BIT)-1:0][31:0]        values,
  input  logic [NUM_WB-1:0]                          wb_valid,
  input  logic [NUM_WB*ROB_WIDTH_BIT-1:0]            wb_id,
  input  logic [NUM_WB*32-1:0]                       wb_value,
  output logic                                       q_ready,
  output logic [31:0]                                q_value
);

  logic        hit_s;
  logic [31:0] hit_value_s;

  // Scan from the highest channel down so the lowest matching channel is the final winner.
  always_comb begin
    hit_s       = 1'b0;
    hit_value_s = 32'd0;
    for (int c = NUM_WB - 1; c >= 0; c--) begin
      if (wb_valid[c] && (wb_id[c*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == q_id)) begin
        hit_s       = 1'b1;
        hit_value_s = wb_value[c*32 +: 32];
      end else begin
        hit_s       = hit_s;
        hit_value_s = hit_value_s;
      end
    end
    if (hit_s) begin
      q_ready = 1'b1;
      q_value = hit_value_s;
    end else if (busy[q_id] && ready[q_id]) begin
      q_ready = 1'b1;
      q_value = values[q_id];
    end else begin
      q_ready = 1'b0;
      q_value = 32'd0;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer with multi-channel writeback, operand forwarding,
// mispredict flush/redirect and a sticky halt on exit.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT,
  parameter int NUM_WB        = DEF_NUM_WB,
  parameter int REG_ID_BIT    = DEF_REG_ID_BIT
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          issue_valid,
  input  logic [1:0]                    issue_kind,
  input  logic [REG_ID_BIT-1:0]         issue_rd,
  input  logic [31:0]                   issue_pc,
  input  logic                          issue_pred_taken,
  output logic                          issue_accept,
  output logic                          rob_full,
  output logic [ROB_WIDTH_BIT-1:0]      rob_free_id,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*ROB_WIDTH_BIT-1:0] wb_id,
  input  logic [NUM_WB*32-1:0]          wb_value,
  input  logic [NUM_WB-1:0]             wb_taken,
  input  logic [NUM_WB*32-1:0]          wb_target,
  input  logic [ROB_WIDTH_BIT-1:0]      q1_id,
  input  logic [ROB_WIDTH_BIT-1:0]      q2_id,
  output logic                          q1_ready,
  output logic                          q2_ready,
  output logic [31:0]                   q1_value,
  output logic [31:0]                   q2_value,
  output logic                          commit_valid,
  output logic [REG_ID_BIT-1:0]         commit_rd,
  output logic [31:0]                   commit_value,
  output logic [ROB_WIDTH_BIT-1:0]      commit_id,
  output logic                          redirect_valid,
  output logic [31:0]                   redirect_pc,
  output logic                          halt_out
);

  localparam int DEPTH = 2 ** ROB_WIDTH_BIT;
  localparam int CNT_W = ROB_WIDTH_BIT + 1;
  localparam logic [ROB_WIDTH_BIT-1:0] ID_ONE    = ROB_WIDTH_BIT'(1);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]         CNT_DEPTH = CNT_W'(DEPTH);

  logic [DEPTH-1:0]                  busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0]                  pred_q, pred_d, taken_q, taken_d;
  logic [DEPTH-1:0][1:0]             kind_q, kind_d;
  logic [DEPTH-1:0][REG_ID_BIT-1:0]  rd_q, rd_d;
  logic [DEPTH-1:0][31:0]            pc_q, pc_d, value_q, value_d, target_q, target_d;
  logic [ROB_WIDTH_BIT-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic                              commit_valid_q, commit_valid_d;
  logic [REG_ID_BIT-1:0]             commit_rd_q, commit_rd_d;
  logic [31:0]                       commit_value_q, commit_value_d;
  logic [ROB_WIDTH_BIT-1:0]          commit_id_q, commit_id_d;
  logic                              redirect_valid_q, redirect_valid_d;
  logic [31:0]                       redirect_pc_q, redirect_pc_d;
  logic                              halt_q, halt_d;

  logic                              head_hit_s, head_taken_s;
  logic [31:0]                       head_value_s, head_target_s;
  logic                              full_s, commit_s, redirect_s, accept_s;
  logic [ROB_WIDTH_BIT-1:0]          wb_idx_s;

  rob_bypass #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT), .NUM_WB(NUM_WB)) u_q1_bypass (
    .q_id(q1_id), .busy(busy_q), .ready(ready_q), .values(value_q),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .q_ready(q1_ready), .q_value(q1_value)
  );

  rob_bypass #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT), .NUM_WB(NUM_WB)) u_q2_bypass (
    .q_id(q2_id), .busy(busy_q), .ready(ready_q), .values(value_q),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .q_ready(q2_ready), .q_value(q2_value)
  );

  // Head result including this cycle's writeback, so a result can retire on the edge it arrives.
  always_comb begin
    head_hit_s    = 1'b0;
    head_value_s  = value_q[head_q];
    head_taken_s  = taken_q[head_q];
    head_target_s = target_q[head_q];
    for (int c = NUM_WB - 1; c >= 0; c--) begin
      if (wb_valid[c] && (wb_id[c*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == head_q)) begin
        head_hit_s    = 1'b1;
        head_value_s  = wb_value[c*32 +: 32];
        head_taken_s  = wb_taken[c];
        head_target_s = wb_target[c*32 +: 32];
      end else begin
        head_hit_s    = head_hit_s;
      end
    end
  end

  assign full_s     = (count_q == CNT_DEPTH);
  assign commit_s   = rdy_in & ~halt_q & busy_q[head_q] & (ready_q[head_q] | head_hit_s);
  assign redirect_s = commit_s & rob_mispredict(kind_q[head_q], pred_q[head_q], head_taken_s);
  assign accept_s   = issue_valid & ~full_s & ~halt_q & ~redirect_s & rdy_in;

  // Next-state: dispatch at tail, writeback into busy entries, retire at head, flush on redirect.
  always_comb begin
    busy_d = busy_q;  ready_d = ready_q;  pred_d = pred_q;  taken_d = taken_q;
    kind_d = kind_q;  rd_d = rd_q;  pc_d = pc_q;  value_d = value_q;  target_d = target_q;
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    commit_valid_d   = commit_valid_q;
    commit_rd_d      = commit_rd_q;
    commit_value_d   = commit_value_q;
    commit_id_d      = commit_id_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    halt_d           = halt_q;
    wb_idx_s         = '0;
    if (rdy_in) begin
      if (accept_s) begin
        busy_d[tail_q]   = 1'b1;
        ready_d[tail_q]  = (issue_kind == ROB_KIND_EXIT);
        kind_d[tail_q]   = issue_kind;
        rd_d[tail_q]     = issue_rd;
        pc_d[tail_q]     = issue_pc;
        pred_d[tail_q]   = issue_pred_taken;
        value_d[tail_q]  = 32'd0;
        taken_d[tail_q]  = 1'b0;
        target_d[tail_q] = 32'd0;
        tail_d           = tail_q + ID_ONE;
      end else begin
        tail_d = tail_q;
      end
      for (int c = 0; c < NUM_WB; c++) begin
        wb_idx_s = wb_id[c*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];
        if (wb_valid[c] && busy_q[wb_idx_s]) begin
          ready_d[wb_idx_s]  = 1'b1;
          value_d[wb_idx_s]  = wb_value[c*32 +: 32];
          taken_d[wb_idx_s]  = wb_taken[c];
          target_d[wb_idx_s] = wb_target[c*32 +: 32];
        end else begin
          ready_d[wb_idx_s]  = ready_d[wb_idx_s];
        end
      end
      commit_valid_d   = commit_s;
      redirect_valid_d = redirect_s;
      if (commit_s) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ID_ONE;
        commit_rd_d    = rd_q[head_q];
        commit_value_d = head_value_s;
        commit_id_d    = head_q;
      end else begin
        head_d = head_q;
      end
      // A full buffer never accepts, so count cannot overflow even while committing.
      case ({accept_s, commit_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (redirect_s) begin
        redirect_pc_d = rob_redirect_pc(kind_q[head_q], pc_q[head_q], head_taken_s, head_target_s);
        busy_d        = '0;
        ready_d       = '0;
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
      end else begin
        redirect_pc_d = redirect_pc_q;
      end
      halt_d = halt_q | (commit_s & (kind_q[head_q] == ROB_KIND_EXIT));
    end else begin
      halt_d = halt_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;  ready_q <= '0;  pred_q <= '0;  taken_q <= '0;
      kind_q <= '0;  rd_q <= '0;  pc_q <= '0;  value_q <= '0;  target_q <= '0;
      head_q <= '0;  tail_q <= '0;  count_q <= '0;
      commit_valid_q   <= 1'b0;
      commit_rd_q      <= '0;
      commit_value_q   <= 32'd0;
      commit_id_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      halt_q           <= 1'b0;
    end else begin
      busy_q <= busy_d;  ready_q <= ready_d;  pred_q <= pred_d;  taken_q <= taken_d;
      kind_q <= kind_d;  rd_q <= rd_d;  pc_q <= pc_d;  value_q <= value_d;  target_q <= target_d;
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
      commit_valid_q   <= commit_valid_d;
      commit_rd_q      <= commit_rd_d;
      commit_value_q   <= commit_value_d;
      commit_id_q      <= commit_id_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      halt_q           <= halt_d;
    end
  end

  assign issue_accept   = accept_s;
  assign rob_full       = full_s;
  assign rob_free_id    = tail_q;
  assign commit_valid   = commit_valid_q;
  assign commit_rd      = commit_rd_q;
  assign commit_value   = commit_value_q;
  assign commit_id      = commit_id_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign halt_out       = halt_q;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Parametrised in-order-commit reorder buffer for the out-of-order core.
- Sits between decoder (dispatch), execution units (NUM_WB writeback channels) and regfile/fetch (commit, redirect).
- Beyond the previous single-channel ROB, it adds:
  - count-based full/empty tracking;
  - multi-channel writeback;
  - operand forwarding with same-cycle bypass;
  - commit;
  - branch-mispredict flush and redirect;
  - exit halt.

Parameters:
- ROB_WIDTH_BIT, 3, log2 of entry count (depth 2**ROB_WIDTH_BIT).
- NUM_WB, 2, number of writeback channels.
- REG_ID_BIT, 5, architectural register index width.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset; the block has one clock, and this reset is asynchronous and active-low.
- rdy_in  in  1  global pause when low.
- issue_valid  in  1  decoder dispatch request.
- issue_kind  in  2  0 normal, 1 branch, 2 jalr, 3 exit.
- issue_rd  in  REG_ID_BIT  destination; 0 = no write.
- issue_pc  in  32  instruction pc.
- issue_pred_taken  in  1  predictor decision (branch only).
- issue_accept  out  1  dispatch accepted this cycle (combinational).
- rob_full  out  1  no free entry.
- rob_free_id  out  ROB_WIDTH_BIT  id assigned to the next dispatch (tail).
- wb_valid  in  NUM_WB  per-channel result valid.
- wb_id  in  NUM_WB*ROB_WIDTH_BIT  per-channel target entry.
- wb_value  in  NUM_WB*32  result value.
- wb_taken  in  NUM_WB  actual branch outcome.
- wb_target  in  NUM_WB*32  actual taken/jalr target.
- q1_id, q2_id  in  ROB_WIDTH_BIT  operand lookup ids.
- q1_ready, q2_ready  out  1  value available.
- q1_value, q2_value  out  32  forwarded value (0 when not ready).
- commit_valid  out  1  one instruction retired this cycle.
- commit_rd  out  REG_ID_BIT  retired destination.
- commit_value  out  32  retired value.
- commit_id  out  ROB_WIDTH_BIT  retired entry id (for regfile tag clear).
- redirect_valid  out  1  flush pipeline and refetch.
- redirect_pc  out  32  refetch address.
- halt_out  out  1  sticky, set when exit retires.

Behaviour:
- Reset:
  - head = tail = count = 0; all busy/ready = 0.
  - commit_valid, redirect_valid, halt_out = 0; commit_rd/value/id = 0; redirect_pc = 0.
- rdy_in low: no state changes; registered outputs hold; issue_accept = 0.
- Full/empty:
  - full = (count == 2**ROB_WIDTH_BIT); empty = (count == 0).
  - count is ROB_WIDTH_BIT+1 bits wide; head and tail wrap modulo depth.
- Dispatch:
  - issue_accept = issue_valid & !rob_full & !halt_out & !flush_pending & rdy_in.
  - On accept, entry[tail] gets busy = 1, ready = (kind==exit), kind, rd, pc, pred; tail++.
  - The id returned to the decoder is rob_free_id in that same cycle.
- Writeback:
  - For each channel c with wb_valid[c] on a busy entry: set ready, value, taken, target.
  - Writes to non-busy entries are ignored.
  - Two channels targeting the same id in one cycle is illegal; the bench asserts against it.
- Forwarding:
  - qN_ready = busy[qN_id] & ready[qN_id], or the id matches a valid wb channel this cycle (bypass, lowest channel wins).
  - qN_value = the matching value, else 0.
- Commit:
  - At most one per cycle, when busy[head] & ready[head].
  - Registered outputs are valid the following cycle: commit_valid pulse, commit_rd, commit_value, commit_id.
  - On commit, busy[head] = 0 and head++.
  - Latency: writeback at cycle N -> commit_valid at N+1 at the earliest.
- Branch commit:
  - Mispredict when taken != pred.
  - redirect_pc = taken ? target : pc+4.
- Jalr commit: always redirects to target.
- Redirect:
  - redirect_valid pulses for 1 cycle, simultaneous with commit_valid.
  - Same edge: all entries busy = 0; head = tail = 0; count = 0; same-cycle dispatch is rejected (flush_pending).
- Exit commit: halt_out = 1 (sticky until reset); no further commits or dispatch.
- Simultaneous dispatch and commit: count unchanged.
  - rob_full is computed from pre-edge count, so a full buffer rejects the dispatch even while committing.
- Reset asserted mid-operation clears state asynchronously; no partial commit is emitted.

Decomposition:
- Shared constants live in const.v:
  - ROB_WIDTH_BIT, REG_ID_BIT;
  - ROB_KIND_NORMAL/BRANCH/JALR/EXIT.
- Sub-module rob_bypass: combinational query/bypass lookup, instantiated twice (q1, q2).

Test Plan:
- Fill: 8 dispatches with kind 0, no writeback -> issue_accept high 8 cycles; rob_full = 1; rob_free_id wraps 0..7; 9th dispatch rejected.
- Out-of-order writeback: ids 2, 1, 0 written with 0x22, 0x11, 0x00 on alternating channels -> commits in order 0, 1, 2 with matching rd and values, one per cycle.
- Bypass: wb_valid[1] with id 3, value 0xDEAD while q1_id = 3 -> q1_ready = 1, q1_value = 0xDEAD in the same cycle.
- Mispredict: branch at pc 0x100 with pred 0, wb taken = 1, target 0x200, three younger entries -> redirect_valid with redirect_pc = 0x200; count = 0; younger entries never commit.
- Correct prediction: pred 1, taken 1 -> commit only, no redirect. Jalr with target 0x40 -> redirect to 0x40.
- Exit retires -> halt_out = 1 held; then assert rst_n_in mid-run -> all outputs 0 asynchronously and rob_free_id = 0.
